// File: rtl/dmem_access_unit.sv
// Load/store access unit between execute and the 32x16 data memory.
// Sequences the level-sensitive mem_read control so each store yields exactly one clean write pulse.
module dmem_access_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [DATA_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_off,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [REG_W-1:0]  req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [REG_W-1:0]  rsp_rd,
    output logic              rsp_store,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] ea;
    logic              addr_err;

    // Offset is sign-extended and the sum wraps at the full data width.
    always_comb begin
        ea       = req_base + {{(DATA_W-ADDR_W){req_off[ADDR_W-1]}}, req_off};
        addr_err = |ea[DATA_W-1:ADDR_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (addr_err) begin
                        state_nx = RESP;
                    end else if (req_store) begin
                        state_nx = ST_SETUP;
                    end else begin
                        state_nx = LD;
                    end
                end
            end
            LD:       state_nx = RESP;
            ST_SETUP: state_nx = ST_WRITE;
            ST_WRITE: state_nx = ST_HOLD;
            ST_HOLD:  state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default:  state_nx = IDLE;
        endcase
    end

    // mem_read is registered from the next state so it is low exactly while in ST_WRITE;
    // address/data only load on leaving IDLE, never on a mem_read edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_store <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            mem_read <= (state_nx != ST_WRITE);
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_rd    <= req_rd;
                        rsp_store <= req_store;
                        rsp_err   <= addr_err;
                        if (addr_err) begin
                            rsp_data <= '0;
                        end else begin
                            mem_addr <= ea[ADDR_W-1:0];
                            if (req_store) begin
                                mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                LD:      rsp_data <= mem_rdata;
                ST_HOLD: rsp_data <= mem_wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed corner cases plus randomized
// requests checked against an array-based memory model.
module tb_dmem_access_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [15:0] req_base;
    logic [4:0]  req_off;
    logic [15:0] req_wdata;
    logic [2:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_rd;
    logic        rsp_store;
    logic        rsp_err;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic [15:0] mem_rdata;

    logic [15:0] mem [32];
    logic [15:0] ref_mem [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [15:0] pl_data;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_access_unit #(.ADDR_W(5), .DATA_W(16), .REG_W(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_base  (req_base),
        .req_off   (req_off),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_rd    (rsp_rd),
        .rsp_store (rsp_store),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stub: combinational read, writes while mem_read is low.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!mem_read) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input bit st, input logic [15:0] base, input logic [4:0] off,
                          input logic [15:0] wd, input logic [2:0] rd, input int bp);
        int          off_s;
        int          ea_i;
        int          lat;
        int          lows;
        int          low_idx;
        int          n;
        bit          err;
        bit          stable;
        logic [4:0]  a0;
        logic [4:0]  low_addr;
        logic [15:0] w0;
        logic [15:0] exp_data;

        off_s = off[4] ? int'(off) - 32 : int'(off);
        ea_i  = (int'(base) + off_s) & 32'hFFFF;
        err   = (ea_i > 31);
        if (err)     exp_data = 16'h0;
        else if (st) exp_data = wd;
        else         exp_data = ref_mem[ea_i];
        if (!err && st) ref_mem[ea_i] = wd;

        @(negedge clk);
        req_valid = 1'b1;
        req_store = st;
        req_base  = base;
        req_off   = off;
        req_wdata = wd;
        req_rd    = rd;
        rsp_ready = (bp == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready, 1);

        @(negedge clk);
        req_valid = 1'b0;
        req_base  = 16'($urandom);
        req_off   = 5'($urandom);
        req_wdata = 16'($urandom);
        lat = 1; lows = 0; low_idx = 0; low_addr = '0; stable = 1'b1;
        a0 = mem_addr;
        w0 = mem_wdata;
        while (!rsp_valid && lat < 20) begin
            if (!mem_read) begin
                lows++;
                low_idx  = lat;
                low_addr = mem_addr;
            end
            if (mem_addr !== a0 || mem_wdata !== w0) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!mem_read) lows++;
        if (mem_addr !== a0 || mem_wdata !== w0) stable = 1'b0;

        check("latency", lat, err ? 1 : (st ? 4 : 2));
        check("write_pulses", lows, (st && !err) ? 1 : 0);
        if (!err) check("mem_addr", a0, ea_i);
        if (st && !err) begin
            check("write_addr", low_addr, ea_i);
            check("write_window", (low_idx > 1 && low_idx < lat), 1);
            check("addr_data_stable", stable, 1);
            check("mem_wdata", w0, wd);
        end
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, err);
        check("rsp_store", rsp_store, st);
        check("rsp_rd", rsp_rd, rd);

        if (bp > 0) begin
            // A competing store is offered during back-pressure; it must not be taken.
            req_valid = 1'b1;
            req_store = 1'b1;
            req_base  = 16'h0;
            req_off   = 5'h0;
            req_wdata = 16'hDEAD;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_rsp_data", rsp_data, exp_data);
                check("bp_rsp_rd", rsp_rd, rd);
                check("bp_rsp_err", rsp_err, err);
                check("bp_req_ready", req_ready, 0);
                check("bp_mem_read", mem_read, 1);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            check("post_hs_req_ready", req_ready, 1);
            check("post_hs_rsp_valid", rsp_valid, 0);
            req_valid = 1'b0;
        end else begin
            @(negedge clk);
            check("post_hs_rsp_valid", rsp_valid, 0);
            check("post_hs_req_ready", req_ready, 1);
        end
    endtask

    task automatic reset_during_write();
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_base  = 16'd3;
        req_off   = 5'd0;
        req_wdata = 16'h1234;
        req_rd    = 3'd5;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (mem_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_write", mem_read, 0);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_mem_read", mem_read, 1);
        check("rst_async_rsp_valid", rsp_valid, 0);
        check("rst_async_req_ready", req_ready, 1);
        // The interrupted write may or may not have landed; adopt whatever the memory holds.
        ref_mem[3] = mem[3];
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_release_req_ready", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_base  = '0;
        req_off   = '0;
        req_wdata = '0;
        req_rd    = '0;
        rsp_ready = 1'b1;
        pl_en     = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            pl_addr    = 5'(i);
            pl_data    = (i == 7) ? 16'd7 : 16'($urandom);
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;

        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_rd", rsp_rd, 0);
        check("reset_rsp_store", rsp_store, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_mem_read", mem_read, 1);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;

        do_req(1'b0, 16'd4, 5'd3, 16'h0, 3'd6, 0);
        do_req(1'b1, 16'd10, 5'b11110, 16'hBEEF, 3'd1, 0);
        do_req(1'b0, 16'd8, 5'd0, 16'h0, 3'd2, 0);
        do_req(1'b0, 16'd31, 5'd1, 16'h0, 3'd3, 0);
        do_req(1'b1, 16'd0, 5'b11111, 16'h5555, 3'd4, 0);
        do_req(1'b0, 16'd31, 5'd0, 16'h0, 3'd5, 0);
        do_req(1'b1, 16'd20, 5'b10000, 16'hA5A5, 3'd7, 0);
        do_req(1'b0, 16'd4, 5'd0, 16'h0, 3'd0, 0);
        do_req(1'b0, 16'd5, 5'd0, 16'h0, 3'd6, 5);

        reset_during_write();
        do_req(1'b0, 16'd8, 5'd0, 16'h0, 3'd1, 0);

        for (int k = 0; k < 60; k++) begin
            logic [15:0] b;
            b = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 47));
            do_req(1'($urandom_range(0, 1)), b, 5'($urandom), 16'($urandom),
                   3'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        mism = 0;
        for (int i = 0; i < 32; i++) begin
            if (mem[i] !== ref_mem[i]) mism++;
        end
        check("final_mem_image", mism, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
